// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_pkg
// Purpose  : Shared constants and fetch packet type for the instruction-fetch
//            stage.
// Revision : 1.0 - initial release
// ============================================================================
package if_pkg;

    localparam int                PC_W       = 16;
    localparam int                INST_W     = 32;
    localparam logic [PC_W-1:0]   PC_STEP    = 16'd4;
    localparam logic [PC_W-1:0]   RESET_PC   = 16'h3000;
    localparam logic [PC_W-1:0]   INT_VECTOR = 16'h0000;
    localparam logic [INST_W-1:0] NOP_INST   = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_pkt_t;

endpackage
`default_nettype wire

// File: rtl/if_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : if_skid_buf
// Purpose  : One-entry skid register for fetch packets with flush.
// Revision : 1.0 - initial release
// ============================================================================
module if_skid_buf
    import if_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_flush,
    input  logic       i_wr_en,
    input  fetch_pkt_t i_wr_pkt,
    input  logic       i_rd_en,
    output logic       o_valid,
    output fetch_pkt_t o_pkt
);

    logic       r_valid;
    fetch_pkt_t r_pkt;

    // A write in the same cycle as a read replaces the entry being drained.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_pkt   <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_wr_en) begin
            r_valid <= 1'b1;
            r_pkt   <= i_wr_pkt;
        end else if (i_rd_en) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_pkt   = r_pkt;

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Purpose  : PC owner and fetch pipeline with skid buffer, redirect and
//            interrupt entry.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
    parameter logic [15:0] RESET_PC   = if_pkg::RESET_PC,
    parameter logic [15:0] INT_VECTOR = if_pkg::INT_VECTOR,
    parameter logic [31:0] NOP_INST   = if_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rstn,
    output logic [15:0] imu_addr,
    input  logic [31:0] imu_dout,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        int_req,
    output logic        int_ack,
    output logic [15:0] epc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_pc,
    output logic [31:0] out_inst
);
    import if_pkg::*;

    logic [15:0] r_pc_q;
    logic        r_infl_v;
    logic [15:0] r_infl_pc;
    logic        r_out_valid;
    logic [15:0] r_out_pc;
    logic [31:0] r_out_inst;
    logic        r_int_ack;
    logic [15:0] r_epc;

    logic        w_skid_v;
    fetch_pkt_t  w_skid_pkt;
    fetch_pkt_t  w_infl_pkt;
    logic        w_refill;
    logic        w_skid_rd;
    logic        w_skid_wr;
    logic        w_skid_next_v;
    logic        w_issue;
    logic        w_int_take;
    logic        w_flush;
    logic [15:0] w_flush_pc;
    logic [15:0] w_epc;

    assign w_infl_pkt.pc   = r_infl_pc;
    assign w_infl_pkt.inst = imu_dout;

    assign w_refill      = !r_out_valid || out_ready;
    assign w_skid_rd     = w_refill && w_skid_v;
    assign w_skid_wr     = r_infl_v && (!w_refill || w_skid_v);
    assign w_skid_next_v = w_skid_wr || (w_skid_v && !w_refill);
    // Only advance the PC when the returning word has a guaranteed home.
    assign w_issue       = !w_skid_next_v;

    assign w_int_take = int_req && !redirect_valid && !r_int_ack;
    assign w_flush    = redirect_valid || w_int_take;
    assign w_flush_pc = redirect_valid ? (redirect_pc & 16'hFFFC) : INT_VECTOR;

    // Return point is the oldest instruction decode has not yet taken.
    always_comb begin
        w_epc = r_pc_q;
        if (r_out_valid && !out_ready) begin
            w_epc = r_out_pc;
        end else if (w_skid_v) begin
            w_epc = w_skid_pkt.pc;
        end else if (r_infl_v) begin
            w_epc = r_infl_pc;
        end
    end

    if_skid_buf u_skid (
        .clk      (clk),
        .rstn     (rstn),
        .i_flush  (w_flush),
        .i_wr_en  (w_skid_wr),
        .i_wr_pkt (w_infl_pkt),
        .i_rd_en  (w_skid_rd),
        .o_valid  (w_skid_v),
        .o_pkt    (w_skid_pkt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc_q      <= RESET_PC;
            r_infl_v    <= 1'b0;
            r_infl_pc   <= '0;
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_out_inst  <= NOP_INST;
            r_int_ack   <= 1'b0;
            r_epc       <= '0;
        end else begin
            r_int_ack <= w_int_take;
            if (w_int_take) begin
                r_epc <= w_epc;
            end
            if (w_flush) begin
                r_pc_q      <= w_flush_pc;
                r_infl_v    <= 1'b0;
                r_out_valid <= 1'b0;
                r_out_inst  <= NOP_INST;
            end else begin
                if (w_issue) begin
                    r_pc_q    <= r_pc_q + PC_STEP;
                    r_infl_pc <= r_pc_q;
                    r_infl_v  <= 1'b1;
                end else begin
                    r_infl_v  <= 1'b0;
                end
                if (w_refill) begin
                    if (w_skid_v) begin
                        r_out_valid <= 1'b1;
                        r_out_pc    <= w_skid_pkt.pc;
                        r_out_inst  <= w_skid_pkt.inst;
                    end else if (r_infl_v) begin
                        r_out_valid <= 1'b1;
                        r_out_pc    <= r_infl_pc;
                        r_out_inst  <= imu_dout;
                    end else begin
                        r_out_valid <= 1'b0;
                        r_out_inst  <= NOP_INST;
                    end
                end
            end
        end
    end

    assign imu_addr  = r_pc_q;
    assign int_ack   = r_int_ack;
    assign epc       = r_epc;
    assign out_valid = r_out_valid;
    assign out_pc    = r_out_pc;
    assign out_inst  = r_out_inst;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_stage
// Purpose  : Scoreboard bench for if_fetch_stage with a 1-cycle memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

    logic        clk;
    logic        rstn;
    logic [15:0] imu_addr;
    logic [31:0] imu_dout;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        int_req;
    logic        int_ack;
    logic [15:0] epc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [31:0] out_inst;

    int          n_checks;
    int          n_fail;
    logic [15:0] sb_q[$];

    if_fetch_stage u_dut (
        .clk            (clk),
        .rstn           (rstn),
        .imu_addr       (imu_addr),
        .imu_dout       (imu_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .int_req        (int_req),
        .int_ack        (int_ack),
        .epc            (epc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [15:0] a);
        return {~a, a} ^ 32'h1357_0000;
    endfunction

    always @(posedge clk) imu_dout <= inst_of(imu_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transfers are judged by decode at the edge; squashed cycles are skipped.
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready && !redirect_valid && !int_req) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", {16'h0, out_pc}, 32'hFFFF_FFFF);
            end else begin
                logic [15:0] e;
                e = sb_q.pop_front();
                check_eq("sb_pc", {16'h0, out_pc}, {16'h0, e});
                check_eq("sb_inst", out_inst, inst_of(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_load(input logic [15:0] start, input int n);
        sb_q.delete();
        for (int i = 0; i < n; i++) sb_q.push_back(start + 16'(4 * i));
    endtask

    task automatic wait_pc(input logic [15:0] pc);
        int n;
        n = 0;
        while (!(out_valid && out_pc == pc) && n < 40) begin
            tick();
            n++;
        end
        check_eq("wait_pc", {15'h0, out_valid, out_pc}, {15'h0, 1'b1, pc});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rstn           = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        int_req        = 1'b0;
        tick();
        tick();
        check_eq("rst_addr", {16'h0, imu_addr}, 32'h3000);
        check_eq("rst_valid", {31'h0, out_valid}, 32'h0);
        check_eq("rst_inst", out_inst, 32'h0000_0013);
        check_eq("rst_pc", {16'h0, out_pc}, 32'h0);
        check_eq("rst_ack", {31'h0, int_ack}, 32'h0);
        check_eq("rst_epc", {16'h0, epc}, 32'h0);

        // startup stream
        sb_load(16'h3000, 16);
        rstn = 1'b1;
        tick();
        check_eq("start_e1_valid", {31'h0, out_valid}, 32'h0);
        check_eq("start_e1_addr", {16'h0, imu_addr}, 32'h3004);
        tick();
        check_eq("start_e2_valid", {31'h0, out_valid}, 32'h1);
        check_eq("start_e2_pc", {16'h0, out_pc}, 32'h3000);
        tick();
        check_eq("start_e3_pc", {16'h0, out_pc}, 32'h3004);

        // backpressure stall at 0x3008
        wait_pc(16'h3008);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_pc", {15'h0, out_valid, out_pc}, {15'h0, 1'b1, 16'h3008});
            check_eq("stall_addr", {16'h0, imu_addr}, 32'h3010);
        end
        out_ready = 1'b1;
        tick();
        check_eq("rel_pc0", {15'h0, out_valid, out_pc}, {15'h0, 1'b1, 16'h300C});
        tick();
        check_eq("rel_pc1", {15'h0, out_valid, out_pc}, {15'h0, 1'b1, 16'h3010});

        // interrupt while 0x3020 waits
        wait_pc(16'h3020);
        out_ready = 1'b0;
        int_req   = 1'b1;
        tick();
        check_eq("int_ack", {31'h0, int_ack}, 32'h1);
        check_eq("int_epc", {16'h0, epc}, 32'h3020);
        check_eq("int_flush", {31'h0, out_valid}, 32'h0);
        int_req   = 1'b0;
        out_ready = 1'b1;
        sb_load(16'h0000, 16);
        tick();
        check_eq("int_ack_drop", {31'h0, int_ack}, 32'h0);
        tick();
        check_eq("vec_pc0", {15'h0, out_valid, out_pc}, {15'h0, 1'b1, 16'h0000});
        tick();
        check_eq("vec_pc1", {15'h0, out_valid, out_pc}, {15'h0, 1'b1, 16'h0004});

        // redirect with a skid entry held
        wait_pc(16'h0008);
        out_ready = 1'b0;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h3102;
        sb_load(16'h3100, 16);
        tick();
        check_eq("redir_v0", {31'h0, out_valid}, 32'h0);
        check_eq("redir_addr", {16'h0, imu_addr}, 32'h3100);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        tick();
        check_eq("redir_v1", {31'h0, out_valid}, 32'h0);
        tick();
        check_eq("redir_pc", {15'h0, out_valid, out_pc}, {15'h0, 1'b1, 16'h3100});
        tick();
        tick();

        // redirect and interrupt together
        redirect_valid = 1'b1;
        redirect_pc    = 16'h3200;
        int_req        = 1'b1;
        sb_q.delete();
        tick();
        check_eq("both_no_ack", {31'h0, int_ack}, 32'h0);
        check_eq("both_addr", {16'h0, imu_addr}, 32'h3200);
        redirect_valid = 1'b0;
        tick();
        check_eq("both_ack", {31'h0, int_ack}, 32'h1);
        check_eq("both_epc", {16'h0, epc}, 32'h3200);
        int_req = 1'b0;
        sb_load(16'h0000, 16);
        tick();
        tick();
        check_eq("both_vec", {15'h0, out_valid, out_pc}, {15'h0, 1'b1, 16'h0000});

        // PC wrap
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFC;
        sb_q.delete();
        sb_q.push_back(16'hFFFC);
        sb_q.push_back(16'h0000);
        sb_q.push_back(16'h0004);
        sb_q.push_back(16'h0008);
        tick();
        check_eq("wrap_addr0", {16'h0, imu_addr}, 32'hFFFC);
        redirect_valid = 1'b0;
        tick();
        check_eq("wrap_addr1", {16'h0, imu_addr}, 32'h0000);
        tick();
        check_eq("wrap_pc0", {15'h0, out_valid, out_pc}, {15'h0, 1'b1, 16'hFFFC});
        tick();
        check_eq("wrap_pc1", {15'h0, out_valid, out_pc}, {15'h0, 1'b1, 16'h0000});

        // asynchronous reset during a stall
        out_ready = 1'b0;
        tick();
        tick();
        sb_q.delete();
        rstn = 1'b0;
        #1;
        check_eq("mrst_valid", {31'h0, out_valid}, 32'h0);
        check_eq("mrst_addr", {16'h0, imu_addr}, 32'h3000);
        check_eq("mrst_inst", out_inst, 32'h0000_0013);
        tick();
        sb_load(16'h3000, 16);
        out_ready = 1'b1;
        rstn = 1'b1;
        tick();
        tick();
        check_eq("mrst_restart", {15'h0, out_valid, out_pc}, {15'h0, 1'b1, 16'h3000});
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction-memory unit.
- Owns the PC, drives the 16-bit fetch address (imu_addr), and absorbs the memory's 1-cycle synchronous read latency.
- Delivers {pc, inst} to decode over a valid/ready handshake, with a 1-entry skid buffer.
- Handles branch/jump redirects and interrupt entry to the interrupt program region 0x0xxx; user code starts at 0x3000.

Parameters:
- RESET_PC, 16'h3000, first fetch address after reset.
- INT_VECTOR, 16'h0000, interrupt entry address.
- NOP_INST, 32'h00000013, value of out_inst while out_valid=0 and after reset.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- imu_addr  out  16  fetch address, combinational from pc_q.
- imu_dout  in  32  instruction for the address presented in the previous cycle.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  16  redirect target; bits [1:0] ignored (forced 0).
- int_req  in  1  level interrupt request.
- int_ack  out  1  one-cycle pulse: interrupt taken.
- epc  out  16  return PC; valid only while int_ack=1.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts this cycle.
- out_pc  out  16  PC of out_inst.
- out_inst  out  32  fetched instruction.

Behaviour:
- Registered state:
  - pc_q: next address to issue.
  - infl_v, infl_pc: address issued last cycle, whose data is on imu_dout now.
  - Output register: out_valid, out_pc, out_inst.
  - Skid entry: skid_v, skid_pc, skid_inst.
- Reset (async, rstn=0):
  - pc_q=RESET_PC; infl_v=0; skid_v=0.
  - out_valid=0, out_pc=0, out_inst=NOP_INST.
  - int_ack=0, epc=0.
  - imu_addr therefore shows RESET_PC during reset.
- Reset mid-operation: all state returns to the reset values immediately; in-flight and buffered instructions are discarded.
- Startup timing:
  - First edge after deassertion: issues RESET_PC.
  - Second edge: out_valid=1, out_pc=0x3000.
  - Thereafter, with out_ready=1: one instruction per cycle, pc += 4.
- Transfer: occurs when out_valid && out_ready.
- Ordering, each edge, no redirect/interrupt:
  1. Refill the output register when it is empty or being transferred: from skid if skid_v, else from infl (if infl_v).
  2. Otherwise infl data goes into skid.
- Issue rule:
  - A new address is issued (pc_q += 4, infl_v<=1) only if skid will be empty after this edge.
  - Otherwise pc_q holds and infl_v<=0. Holding the address keeps memory output coherent.
  - No instruction is ever dropped or duplicated under arbitrary out_ready patterns.
- PC arithmetic: 16-bit, step 4, wraps 16'hFFFC -> 16'h0000 with no flag.
- Redirect (redirect_valid=1 at edge):
  - pc_q <= {redirect_pc[15:2],2'b00}.
  - infl_v, skid_v, out_valid all cleared, including any transfer happening in that same cycle.
  - The decoder treats a same-cycle transfer as squashed.
  - The target instruction appears on out_valid 2 edges later.
- Interrupt:
  - Taken at an edge where int_req=1, redirect_valid=0, and int_ack was not asserted in the previous cycle.
  - epc = PC of the oldest instruction not yet transferred, in priority order: out_pc (out_valid && !out_ready) > skid_pc > infl_pc > pc_q.
  - int_ack=1 for exactly that cycle (combinational decision, registered pulse aligned with the flush).
  - Flushes exactly like a redirect to INT_VECTOR.
- Simultaneous events: redirect beats interrupt. A pending int_req is retried the cycle after the redirect; epc is then the redirect target.
- int_req held high: re-taken every other cycle at most. Masking is the interrupt controller's responsibility.

Decomposition:
- Shared package if_pkg:
  - Constants: PC_W=16, INST_W=32, PC_STEP=4, RESET_PC, INT_VECTOR, NOP_INST.
  - Typedef fetch_pkt_t {pc, inst}.
- Natural sub-module: if_skid_buf, a 1-entry valid/ready skid holding fetch_pkt_t, with a flush input.

Test Plan:
- Reset release with out_ready=1 and memory preloaded (0x3000->A, 0x3004->B) -> out_valid on 2nd edge, out_pc 0x3000/A then 0x3004/B back-to-back; imu_addr 0x3000 during reset.
- out_ready low for 3 cycles mid-stream at 0x3008 -> out_pc held at 0x3008; imu_addr stalls one address later; on release, 0x300C, 0x3010 delivered in order with no gap, loss or duplicate.
- redirect_valid with redirect_pc=0x3102 while a skid entry is valid -> out_valid=0 for 2 cycles; next out_pc=0x3100.
- int_req pulse while out_pc=0x3020 is unaccepted -> int_ack one cycle, epc=0x3020; next delivered out_pc=0x0000, then 0x0004.
- redirect_valid and int_req same cycle -> redirect taken, no int_ack; next cycle int_ack with epc = redirect target.
- pc_q at 0xFFFC -> next issued imu_addr 0x0000; rstn asserted mid-stall -> out_valid=0, pc back to 0x3000 immediately.
